// File: rtl/adder_seq.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered carry between chunks.
// Results and flags update only on the done edge; start/busy/done handshake.
module adder_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] rA,
   input  logic [WIDTH-1:0] rB,
   input  logic             cIn,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             cOut,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : gBadParam
      $error("adder_seq: WIDTH must be a positive multiple of CHUNK");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, nextState;
   logic [WIDTH-1:0]  opA, opB, sumReg, sumNext;
   logic              carry;
   logic [CW-1:0]     cnt;
   logic [CHUNK-1:0]  aI, bI, sI;
   logic              cyI, msbIn, lastChunk, accept;

   assign busy      = (state == RUN);
   assign accept    = (state == IDLE) && start;
   assign lastChunk = (cnt == CW'(N - 1));

   // Chunk mux with constant part-selects keeps the index widths exact.
   always_comb begin
      aI      = '0;
      bI      = '0;
      sumNext = sumReg;
      for (int j = 0; j < N; j++) begin
         if (cnt == CW'(j)) begin
            aI = opA[j*CHUNK +: CHUNK];
            bI = opB[j*CHUNK +: CHUNK];
         end
      end
      {cyI, sI} = {1'b0, aI} + {1'b0, bI} + {{CHUNK{1'b0}}, carry};
      for (int j = 0; j < N; j++) begin
         if (cnt == CW'(j)) sumNext[j*CHUNK +: CHUNK] = sI;
      end
      // Carry into the top bit of the chunk, recovered from its sum bit.
      msbIn = aI[CHUNK-1] ^ bI[CHUNK-1] ^ sI[CHUNK-1];
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (lastChunk) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state <= IDLE;
      else          state <= nextState;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         opA    <= '0;
         opB    <= '0;
         sumReg <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         S      <= '0;
         cOut   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            opA   <= rA;
            opB   <= sub ? ~rB : rB;
            carry <= sub ? 1'b1 : cIn;
            cnt   <= '0;
         end else if (state == RUN) begin
            sumReg <= sumNext;
            carry  <= cyI;
            cnt    <= lastChunk ? '0 : cnt + 1'b1;
            if (lastChunk) begin
               S    <= sumNext;
               cOut <= cyI;
               ovf  <= msbIn ^ cyI;
               zero <= (sumNext == '0);
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboarded bench for adder_seq: directed and random ops on CHUNK=4,
// then random ops on CHUNK=1, 32 and 8 instances against a signed/unsigned arithmetic model.
module tb_adder_seq;

   localparam int W  = 32;
   localparam int N0 = 8;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         z;
   } res_t;

   logic clock = 1'b0;
   logic clear_n = 1'b0;
   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   bit phase2 = 1'b0;

   always @(posedge clock) cyc++;

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic su);
      longint sa, sb, sr, ua, ub, ur;
      longint maxS;
      res_t r;
      maxS = 2147483647;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (su) begin
         sr = sa - sb;
         ur = ua - ub;
         r.c = (ua >= ub);
      end else begin
         sr = sa + sb + longint'(ci);
         ur = ua + ub + longint'(ci);
         r.c = ur[32];
      end
      r.s = ur[31:0];
      r.o = (sr > maxS) || (sr < -maxS - 1);
      r.z = (r.s == '0);
      return r;
   endfunction

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   // ---------------- main instance, CHUNK=4 ----------------
   logic          start = 1'b0, sub = 1'b0, cIn = 1'b0;
   logic [W-1:0]  rA = '0, rB = '0;
   logic          busy, done, cOut, ovf, zero;
   logic [W-1:0]  S;

   adder_seq #(.WIDTH(W), .CHUNK(4)) u0 (
      .clock(clock), .clear_n(clear_n), .start(start), .sub(sub), .rA(rA), .rB(rB),
      .cIn(cIn), .busy(busy), .done(done), .S(S), .cOut(cOut), .ovf(ovf), .zero(zero));

   res_t q0[$];
   res_t prevOut;
   bit   prevValid = 1'b0;
   logic prevDone = 1'b0;

   always @(negedge clock) begin
      res_t cur, e;
      cur = '{s: S, c: cOut, o: ovf, z: zero};
      if (!clear_n) begin
         prevValid = 1'b0;
         prevDone  = 1'b0;
      end else begin
         if (done) begin
            if (prevDone) check("donePulseWidth", 64'(prevDone & done), 64'd0);
            if (q0.size() == 0) check("unexpectedDone", 64'(done), 64'd0);
            else begin
               e = q0.pop_front();
               check("S", 64'(S), 64'(e.s));
               check("cOut", 64'(cOut), 64'(e.c));
               check("ovf", 64'(ovf), 64'(e.o));
               check("zero", 64'(zero), 64'(e.z));
            end
         end else if (prevValid) begin
            check("outputsHeld", 64'(cur), 64'(prevOut));
         end
         prevOut   = cur;
         prevValid = 1'b1;
         prevDone  = done;
      end
   end

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic su, input bit junk);
      int n, busyCnt;
      bit got;
      @(negedge clock);
      rA = a; rB = b; cIn = ci; sub = su; start = 1'b1;
      q0.push_back(model(a, b, ci, su));
      n = 0; busyCnt = 0; got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clock);
         n++;
         if (done) got = 1'b1;
         else if (busy) busyCnt++;
         // Inputs churn while busy; a stray start mid-operation must be ignored.
         start = (junk && !got && busyCnt == 2);
         if (!got) begin
            rA = $urandom; rB = $urandom; cIn = 1'($urandom); sub = 1'($urandom);
         end
      end
      check("doneWithinBound", 64'(got), 64'd1);
      check("busyCycles", 64'(busyCnt), 64'(N0));
      check("busyLowAtDone", 64'(busy), 64'd0);
   endtask

   // ---------------- extra instances: CHUNK 1, 32, 8 ----------------
   for (genvar g = 0; g < 3; g++) begin : gx
      localparam int CH = (g == 0) ? 1 : (g == 1) ? 32 : 8;
      localparam int NX = W / CH;
      logic         st = 1'b0, su = 1'b0, ci = 1'b0;
      logic [W-1:0] a = '0, b = '0, s;
      logic         bz, dn, co, ov, zr;
      res_t         q[$];
      bit           fin = 1'b0;

      adder_seq #(.WIDTH(W), .CHUNK(CH)) ux (
         .clock(clock), .clear_n(clear_n), .start(st), .sub(su), .rA(a), .rB(b),
         .cIn(ci), .busy(bz), .done(dn), .S(s), .cOut(co), .ovf(ov), .zero(zr));

      initial begin
         int n, cnt;
         bit got;
         wait (phase2);
         for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            a = $urandom; b = (k == 0) ? a : $urandom;
            ci = 1'($urandom); su = (k == 0) ? 1'b1 : 1'($urandom); st = 1'b1;
            q.push_back(model(a, b, ci, su));
            n = 0; cnt = 0; got = 1'b0;
            while (!got && n < 200) begin
               @(negedge clock);
               n++;
               st = 1'b0;
               if (dn) got = 1'b1;
               else if (bz) cnt++;
               a = $urandom; b = $urandom;
            end
            check($sformatf("doneWithinBound_ch%0d", CH), 64'(got), 64'd1);
            check($sformatf("busyCycles_ch%0d", CH), 64'(cnt), 64'(NX));
         end
         fin = 1'b1;
      end

      always @(negedge clock) begin
         res_t e;
         if (clear_n && dn) begin
            if (q.size() == 0) check($sformatf("unexpectedDone_ch%0d", CH), 64'(dn), 64'd0);
            else begin
               e = q.pop_front();
               check($sformatf("S_ch%0d", CH), 64'(s), 64'(e.s));
               check($sformatf("cOut_ch%0d", CH), 64'(co), 64'(e.c));
               check($sformatf("ovf_ch%0d", CH), 64'(ov), 64'(e.o));
               check($sformatf("zero_ch%0d", CH), 64'(zr), 64'(e.z));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n, dn, lastDone;
      bit sawDone, allFin;

      repeat (3) @(negedge clock);
      #2 clear_n = 1'b1;
      @(negedge clock);
      check("rstBusy", 64'(busy), 64'd0);
      check("rstDone", 64'(done), 64'd0);
      check("rstS", 64'(S), 64'd0);
      check("rstCOut", 64'(cOut), 64'd0);
      check("rstOvf", 64'(ovf), 64'd0);
      check("rstZero", 64'(zero), 64'd0);

      run(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
      run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      run(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
      run(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
      run(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      run(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
      run(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);

      // Start held high: each new op is accepted in the previous op's done cycle.
      @(negedge clock);
      rA = $urandom; rB = $urandom; cIn = 1'($urandom); sub = 1'($urandom); start = 1'b1;
      q0.push_back(model(rA, rB, cIn, sub));
      dn = 0; lastDone = 0; n = 0;
      while (dn < 3 && n < 100) begin
         @(negedge clock);
         n++;
         if (done) begin
            dn++;
            if (dn > 1) check("b2bPeriod", 64'(cyc - lastDone), 64'(N0 + 1));
            lastDone = cyc;
            rA = $urandom; rB = $urandom; cIn = 1'($urandom); sub = 1'($urandom);
            if (dn < 3) q0.push_back(model(rA, rB, cIn, sub));
            else start = 1'b0;
         end else begin
            rA = $urandom; rB = $urandom; cIn = 1'($urandom); sub = 1'($urandom);
         end
      end
      check("b2bCount", 64'(dn), 64'd3);

      // Make sure S is non-zero before the abort so the reset check has teeth.
      run(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      rA = 32'h0000_1111; rB = 32'h0000_2222; cIn = 1'b0; sub = 1'b0; start = 1'b1;
      q0.push_back(model(rA, rB, cIn, sub));
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      #2 clear_n = 1'b0;
      #1;
      check("abortBusy", 64'(busy), 64'd0);
      check("abortDone", 64'(done), 64'd0);
      check("abortS", 64'(S), 64'd0);
      check("abortCOut", 64'(cOut), 64'd0);
      check("abortOvf", 64'(ovf), 64'd0);
      check("abortZero", 64'(zero), 64'd0);
      q0.delete();
      @(negedge clock);
      #2 clear_n = 1'b1;
      sawDone = 1'b0;
      repeat (12) begin
         @(negedge clock);
         if (done) sawDone = 1'b1;
      end
      check("noDoneAfterAbort", 64'(sawDone), 64'd0);
      run(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < 20; k++)
         run($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));

      phase2 = 1'b1;
      n = 0;
      allFin = 1'b0;
      while (!allFin && n < 6000) begin
         @(negedge clock);
         n++;
         allFin = gx[0].fin && gx[1].fin && gx[2].fin;
      end
      check("extrasFinished", 64'(allFin), 64'd1);
      repeat (2) @(negedge clock);
      check("scoreboardDrained", 64'(q0.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
Parametrised multi-cycle add/subtract unit for the datapath ALU. It replaces the fixed 32-bit combinational adder where timing or area is tight. It processes CHUNK bits per clock with a registered carry between chunks, under a start/busy/done handshake. It also produces carry, signed-overflow and zero flags, which the combinational adder does not provide.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits summed per clock cycle; 1 <= CHUNK <= WIDTH.

Ports:
clock  in  1  rising-edge clock.
clear_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only while idle (busy=0).
sub  in  1  0: S = rA + rB + cIn; 1: S = rA + ~rB + 1 (cIn ignored).
rA  in  WIDTH  operand A; captured on the accepted start.
rB  in  WIDTH  operand B; captured on the accepted start.
cIn  in  1  carry-in for add; captured on the accepted start.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse; result outputs are valid from this cycle.
S  out  WIDTH  registered result.
cOut  out  1  carry out of the MSB (for sub: 1 = no borrow).
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
zero  out  1  1 when S == 0.

Behaviour:
- Reset: clear_n low forces, asynchronously, state=IDLE, busy=0, done=0, S=0, cOut=0, ovf=0, zero=0, and clears the chunk counter, the internal operand and sum registers and the carry register.
- N = WIDTH/CHUNK. The counter width is max(1, ceil(log2 N)).
- States: IDLE and RUN.
- IDLE, start=1 at edge k:
  - latch rA and (sub ? ~rB : rB) into internal registers;
  - carry register <= (sub ? 1 : cIn); counter <= 0; busy <= 1; go to RUN.
- IDLE, start=0: hold state. S and the flags keep their last values.
- RUN, each edge: compute chunk i = counter, bits [i*CHUNK +: CHUNK]:
  - sum = A_i + B_i + carry, written into the internal sum register at chunk i;
  - carry <= carry out of the chunk; counter increments.
- When CHUNK = 1, the chunk's own carry-in is also the carry into the MSB.
- RUN, last chunk (counter == N-1), at edge k+N:
  - S <= full sum; cOut <= chunk carry-out;
  - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - zero <= (full sum == 0);
  - done <= 1; busy <= 0; return to IDLE.
- Latency: start accepted at edge k → done high for exactly one cycle after edge k+N. busy is high for N cycles. CHUNK=WIDTH gives a latency of 1.
- done deasserts at the next edge unconditionally.
- A start presented while done=1 is accepted at that edge. Back-to-back throughput is one result per N+1 cycles.
- start while busy=1 is ignored: no queueing and no effect on the result.
- rA, rB, cIn and sub may change freely after acceptance; the in-flight operation uses the latched values.
- S and the flags change only at a done edge or on reset. They are never partially updated mid-operation.
- clear_n asserted mid-operation aborts the operation: outputs go to their reset values and no done pulse is produced.
- Arithmetic is modulo 2^WIDTH. Flags follow two's-complement rules.

Test Plan:
- WIDTH=32, CHUNK=4, reset, then start with rA=0x00000005, rB=0x00000003, cIn=0, sub=0 → busy high for 8 cycles, done pulse in cycle 9, S=0x00000008, cOut=0, ovf=0, zero=0.
- rA=0xFFFFFFFF, rB=0x00000001, add → S=0x00000000, cOut=1, ovf=0, zero=1. rA=0x7FFFFFFF, rB=0x00000001 → S=0x80000000, ovf=1, cOut=0.
- sub=1, rA=5, rB=7, cIn=1 (ignored) → S=0xFFFFFFFE, cOut=0, ovf=0. sub=1, rA=0x80000000, rB=1 → S=0x7FFFFFFF, ovf=1, cOut=1.
- Hold start=1 continuously, change rA and rB mid-operation → the first result uses the latched operands. The next operation is accepted in the done cycle, so done pulses every 9 cycles.
- Pull clear_n low at cycle 4 of an operation → all outputs go to 0 immediately, no done pulse. A new start after release completes normally.
- Re-run with CHUNK=1 (done after 32 busy cycles), CHUNK=32 (done after 1) and CHUNK=8 using random operands → S, cOut and ovf match the reference model rA ± rB.
